// File: rtl/equiv_monitor.sv
// Equivalence monitor: aligns two implementation outputs by per-side latency,
// compares them after a warm-up window, and keeps sticky failure status.
module equiv_monitor #(
  parameter int WIDTH  = 91,
  parameter int LAT_A  = 0,
  parameter int LAT_B  = 0,
  parameter int WARMUP = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] first_cyc,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_WARM  = 2'b00,
    ST_CHECK = 2'b01,
    ST_FAIL  = 2'b10
  } state_t;

  localparam int LAT_E = (LAT_A > LAT_B) ? LAT_A : LAT_B;
  localparam int WW    = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

  localparam logic [WW-1:0]    WARM_LAST = WW'(WARMUP - 1);
  localparam logic [WW-1:0]    WARM_ONE  = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0]    WARM_ZERO = {WW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] DAT_ZERO  = {WIDTH{1'b0}};

  state_t           state_r;
  logic [WW-1:0]    warm_cnt_r;
  logic [WIDTH-1:0] a_al_s;
  logic [WIDTH-1:0] b_al_s;
  logic             en_al_s;
  logic             hit_s;
  logic [CNT_W-1:0] cyc_inc_s;
  logic [CNT_W-1:0] mis_inc_s;

  generate
    if (LAT_A == 0) begin : g_a_pass
      assign a_al_s = y_a;
    end else begin : g_a_dly
      logic [WIDTH-1:0] dly_r [LAT_A];
      // y_a delay line; cleared only by rst so clear leaves alignment intact
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT_A; i++) dly_r[i] <= DAT_ZERO;
        end else begin
          dly_r[0] <= y_a;
          for (int i = 1; i < LAT_A; i++) dly_r[i] <= dly_r[i-1];
        end
      end
      assign a_al_s = dly_r[LAT_A-1];
    end

    if (LAT_B == 0) begin : g_b_pass
      assign b_al_s = y_b;
    end else begin : g_b_dly
      logic [WIDTH-1:0] dly_r [LAT_B];
      // y_b delay line
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT_B; i++) dly_r[i] <= DAT_ZERO;
        end else begin
          dly_r[0] <= y_b;
          for (int i = 1; i < LAT_B; i++) dly_r[i] <= dly_r[i-1];
        end
      end
      assign b_al_s = dly_r[LAT_B-1];
    end

    if (LAT_E == 0) begin : g_e_pass
      assign en_al_s = en;
    end else begin : g_e_dly
      logic dly_r [LAT_E];
      // en follows the slower side so it qualifies the same aligned sample
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT_E; i++) dly_r[i] <= 1'b0;
        end else begin
          dly_r[0] <= en;
          for (int i = 1; i < LAT_E; i++) dly_r[i] <= dly_r[i-1];
        end
      end
      assign en_al_s = dly_r[LAT_E-1];
    end
  endgenerate

  // Aligned compare plus saturating next-count values
  always_comb begin
    hit_s = 1'b0;
    if (state_r != ST_WARM) begin
      hit_s = en_al_s & (a_al_s != b_al_s);
    end else begin
      hit_s = 1'b0;
    end
    cyc_inc_s = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_ONE;
    mis_inc_s = (mismatch_cnt == CNT_MAX) ? mismatch_cnt : mismatch_cnt + CNT_ONE;
  end

  // Monitor FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_WARM;
      warm_cnt_r   <= WARM_ZERO;
      mismatch     <= 1'b0;
      fail         <= 1'b0;
      mismatch_cnt <= CNT_ZERO;
      cycle_cnt    <= CNT_ZERO;
      first_cyc    <= CNT_ZERO;
      first_a      <= DAT_ZERO;
      first_b      <= DAT_ZERO;
    end else begin
      case (state_r)
        ST_WARM: begin
          mismatch <= 1'b0;
          if (warm_cnt_r == WARM_LAST) begin
            state_r    <= ST_CHECK;
            warm_cnt_r <= WARM_ZERO;
          end else begin
            warm_cnt_r <= warm_cnt_r + WARM_ONE;
          end
        end
        ST_CHECK, ST_FAIL: begin
          if (clear) begin
            // clear wins over a same-cycle hit
            state_r      <= ST_CHECK;
            mismatch     <= 1'b0;
            fail         <= 1'b0;
            mismatch_cnt <= CNT_ZERO;
            cycle_cnt    <= CNT_ZERO;
            first_cyc    <= CNT_ZERO;
            first_a      <= DAT_ZERO;
            first_b      <= DAT_ZERO;
          end else begin
            cycle_cnt <= cyc_inc_s;
            mismatch  <= hit_s;
            if (hit_s) begin
              fail         <= 1'b1;
              mismatch_cnt <= mis_inc_s;
              if (state_r == ST_CHECK) begin
                state_r   <= ST_FAIL;
                first_cyc <= cycle_cnt;
                first_a   <= a_al_s;
                first_b   <= b_al_s;
              end else begin
                state_r <= ST_FAIL;
              end
            end else begin
              state_r <= state_r;
            end
          end
        end
        default: begin
          state_r    <= ST_WARM;
          warm_cnt_r <= WARM_ZERO;
          mismatch   <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_equiv_monitor.sv
// Scoreboard bench for equiv_monitor: three parameterisations driven side by side,
// each checked every cycle against a behavioural model, plus directed checks.
module tb_equiv_monitor;

  typedef struct {
    logic        mis;
    logic        fail;
    int          mcnt;
    int          ccnt;
    int          fcyc;
    logic [90:0] fa;
    logic [90:0] fb;
    int          st;
  } exp_t;

  localparam int LA [3] = '{0, 2, 1};
  localparam int LB [3] = '{0, 0, 3};
  localparam int WU [3] = '{4, 4, 2};
  localparam int CW [3] = '{16, 16, 4};

  logic clk = 1'b0;
  logic rst_s;
  logic [90:0] ya_s [3];
  logic [90:0] yb_s [3];
  logic        en_s [3];
  logic        clr_s [3];

  logic        mis_o [3];
  logic        fail_o [3];
  logic [15:0] mcnt_o [2];
  logic [15:0] ccnt_o [2];
  logic [15:0] fcyc_o [2];
  logic [3:0]  mcnt2_o, ccnt2_o, fcyc2_o;
  logic [90:0] fa_o [3];
  logic [90:0] fb_o [3];
  logic [1:0]  st_o [3];

  int checks = 0;
  int failures = 0;

  // reference-model state per instance
  int          m_st [3];
  int          m_w [3];
  int          m_cyc [3];
  int          m_mcnt [3];
  int          m_fcyc [3];
  logic [90:0] m_fa [3];
  logic [90:0] m_fb [3];
  logic        m_fail [3];
  logic        m_mis [3];
  logic [90:0] ha [3][8];
  logic [90:0] hb [3][8];
  logic        he [3][8];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  equiv_monitor #(.WIDTH(91), .LAT_A(0), .LAT_B(0), .WARMUP(4), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst_s), .en(en_s[0]), .clear(clr_s[0]), .y_a(ya_s[0]), .y_b(yb_s[0]),
    .mismatch(mis_o[0]), .fail(fail_o[0]), .mismatch_cnt(mcnt_o[0]), .cycle_cnt(ccnt_o[0]),
    .first_cyc(fcyc_o[0]), .first_a(fa_o[0]), .first_b(fb_o[0]), .state(st_o[0]));

  equiv_monitor #(.WIDTH(91), .LAT_A(2), .LAT_B(0), .WARMUP(4), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst_s), .en(en_s[1]), .clear(clr_s[1]), .y_a(ya_s[1]), .y_b(yb_s[1]),
    .mismatch(mis_o[1]), .fail(fail_o[1]), .mismatch_cnt(mcnt_o[1]), .cycle_cnt(ccnt_o[1]),
    .first_cyc(fcyc_o[1]), .first_a(fa_o[1]), .first_b(fb_o[1]), .state(st_o[1]));

  equiv_monitor #(.WIDTH(91), .LAT_A(1), .LAT_B(3), .WARMUP(2), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst_s), .en(en_s[2]), .clear(clr_s[2]), .y_a(ya_s[2]), .y_b(yb_s[2]),
    .mismatch(mis_o[2]), .fail(fail_o[2]), .mismatch_cnt(mcnt2_o), .cycle_cnt(ccnt2_o),
    .first_cyc(fcyc2_o), .first_a(fa_o[2]), .first_b(fb_o[2]), .state(st_o[2]));

  function automatic logic [90:0] rnd91();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[90:0];
  endfunction

  function automatic int act_mcnt(int k);
    if (k == 2) return int'(mcnt2_o);
    else return int'(mcnt_o[k]);
  endfunction

  function automatic int act_ccnt(int k);
    if (k == 2) return int'(ccnt2_o);
    else return int'(ccnt_o[k]);
  endfunction

  function automatic int act_fcyc(int k);
    if (k == 2) return int'(fcyc2_o);
    else return int'(fcyc_o[k]);
  endfunction

  task automatic chk(string name, int k, logic [90:0] act, logic [90:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h want=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Expected outputs after the coming clock edge, from the monitor's rules
  task automatic model_step(int k);
    logic [90:0] a_al, b_al;
    logic        e_al, hit;
    int          le, mx;
    exp_t        e;
    mx = (1 << CW[k]) - 1;
    le = (LA[k] > LB[k]) ? LA[k] : LB[k];
    if (LA[k] == 0) a_al = ya_s[k]; else a_al = ha[k][LA[k]-1];
    if (LB[k] == 0) b_al = yb_s[k]; else b_al = hb[k][LB[k]-1];
    if (le == 0) e_al = en_s[k]; else e_al = he[k][le-1];
    if (rst_s) begin
      m_st[k] = 0; m_w[k] = 0; m_cyc[k] = 0; m_mcnt[k] = 0; m_fcyc[k] = 0;
      m_fa[k] = '0; m_fb[k] = '0; m_fail[k] = 1'b0; m_mis[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        ha[k][i] = '0; hb[k][i] = '0; he[k][i] = 1'b0;
      end
    end else begin
      hit = e_al && (a_al != b_al) && (m_st[k] != 0);
      for (int i = 7; i > 0; i--) begin
        ha[k][i] = ha[k][i-1]; hb[k][i] = hb[k][i-1]; he[k][i] = he[k][i-1];
      end
      ha[k][0] = ya_s[k]; hb[k][0] = yb_s[k]; he[k][0] = en_s[k];
      if (m_st[k] == 0) begin
        m_mis[k] = 1'b0;
        m_w[k]++;
        if (m_w[k] == WU[k]) m_st[k] = 1;
      end else if (clr_s[k]) begin
        m_st[k] = 1; m_cyc[k] = 0; m_mcnt[k] = 0; m_fcyc[k] = 0;
        m_fa[k] = '0; m_fb[k] = '0; m_fail[k] = 1'b0; m_mis[k] = 1'b0;
      end else begin
        m_mis[k] = hit;
        if (hit) begin
          if (m_st[k] == 1) begin
            m_fcyc[k] = m_cyc[k]; m_fa[k] = a_al; m_fb[k] = b_al; m_st[k] = 2;
          end
          m_fail[k] = 1'b1;
          m_mcnt[k] = (m_mcnt[k] < mx) ? m_mcnt[k] + 1 : mx;
        end
        m_cyc[k] = (m_cyc[k] < mx) ? m_cyc[k] + 1 : mx;
      end
    end
    e.mis = m_mis[k]; e.fail = m_fail[k]; e.mcnt = m_mcnt[k]; e.ccnt = m_cyc[k];
    e.fcyc = m_fcyc[k]; e.fa = m_fa[k]; e.fb = m_fb[k]; e.st = m_st[k];
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #2;
  endtask

  task automatic rand_in(int k);
    ya_s[k] = rnd91();
    yb_s[k] = ($urandom_range(0, 1) == 0) ? ya_s[k] : rnd91();
    en_s[k] = ($urandom_range(0, 3) != 0);
    clr_s[k] = ($urandom_range(0, 15) == 0);
  endtask

  // Scoreboard monitor: pops one expectation per instance each cycle
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int k = 0; k < 3; k++) begin
      if ((k == 0 && q0.size() > 0) || (k == 1 && q1.size() > 0) || (k == 2 && q2.size() > 0)) begin
        if (k == 0) e = q0.pop_front();
        else if (k == 1) e = q1.pop_front();
        else e = q2.pop_front();
        chk("mismatch", k, 91'(mis_o[k]), 91'(e.mis));
        chk("fail", k, 91'(fail_o[k]), 91'(e.fail));
        chk("mismatch_cnt", k, 91'(act_mcnt(k)), 91'(e.mcnt));
        chk("cycle_cnt", k, 91'(act_ccnt(k)), 91'(e.ccnt));
        chk("first_cyc", k, 91'(act_fcyc(k)), 91'(e.fcyc));
        chk("first_a", k, fa_o[k], e.fa);
        chk("first_b", k, fb_o[k], e.fb);
        chk("state", k, 91'(st_o[k]), 91'(e.st));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout no_finish checks=%0d", checks);
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    logic [90:0] va, vb, p1, p2, v;
    logic        seen;

    // warm-up window after a one-cycle reset
    rst_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ya_s[k] = 91'h5; yb_s[k] = 91'h5; en_s[k] = 1'b1; clr_s[k] = 1'b0;
    end
    tick();
    rst_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("warm_state", 0, 91'(st_o[0]), 91'd0);
      chk("warm_mismatch", 0, 91'(mis_o[0]), 91'd0);
      tick();
    end
    chk("check_entry", 0, 91'(st_o[0]), 91'd1);

    // first mismatch capture at cycle_cnt 10
    for (int i = 0; i < 10; i++) tick();
    chk("cyc_before_hit", 0, 91'(ccnt_o[0]), 91'd10);
    for (int k = 0; k < 3; k++) begin
      ya_s[k] = 91'h1; yb_s[k] = 91'h0;
    end
    tick();
    chk("hit_mismatch", 0, 91'(mis_o[0]), 91'd1);
    chk("hit_fail", 0, 91'(fail_o[0]), 91'd1);
    chk("hit_cnt", 0, 91'(mcnt_o[0]), 91'd1);
    chk("hit_first_cyc", 0, 91'(fcyc_o[0]), 91'd10);
    chk("hit_first_a", 0, fa_o[0], 91'h1);
    chk("hit_first_b", 0, fb_o[0], 91'h0);
    chk("hit_state", 0, 91'(st_o[0]), 91'd2);

    // clear beats a simultaneous hit
    ya_s[0] = 91'h3; yb_s[0] = 91'h4; en_s[0] = 1'b1; clr_s[0] = 1'b1;
    rand_in(1); rand_in(2);
    tick();
    chk("clr_fail", 0, 91'(fail_o[0]), 91'd0);
    chk("clr_cnt", 0, 91'(mcnt_o[0]), 91'd0);
    chk("clr_state", 0, 91'(st_o[0]), 91'd1);
    chk("clr_mismatch", 0, 91'(mis_o[0]), 91'd0);
    chk("clr_cycle", 0, 91'(ccnt_o[0]), 91'd0);

    // en low masks differences while cycles still count
    clr_s[0] = 1'b0; en_s[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      ya_s[0] = rnd91(); yb_s[0] = ~ya_s[0];
      rand_in(1); rand_in(2);
      tick();
    end
    chk("en_off_fail", 0, 91'(fail_o[0]), 91'd0);
    chk("en_off_cnt", 0, 91'(mcnt_o[0]), 91'd0);
    chk("en_off_cycle", 0, 91'(ccnt_o[0]), 91'd50);

    // saturation on the 4-bit instance, first sample held
    va = rnd91(); va[89] = 1'b0; vb = va; vb[90] = ~va[90];
    ya_s[2] = va; yb_s[2] = vb; en_s[2] = 1'b1; clr_s[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in(0); rand_in(1);
      tick();
    end
    clr_s[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ya_s[2] = va + 91'(i + 1);
      rand_in(0); rand_in(1);
      tick();
    end
    chk("sat_cnt", 2, 91'(mcnt2_o), 91'd15);
    chk("sat_cycle", 2, 91'(ccnt2_o), 91'd15);
    chk("sat_first_a", 2, fa_o[2], va);
    chk("sat_first_b", 2, fb_o[2], vb);
    chk("sat_first_cyc", 2, 91'(fcyc2_o), 91'd0);
    chk("sat_state", 2, 91'(st_o[2]), 91'd2);

    // LAT_A=2 instance fed a correctly delayed y_b stays clean
    p1 = '0; p2 = '0;
    for (int i = 0; i < 1002; i++) begin
      v = rnd91();
      ya_s[1] = v; yb_s[1] = p2; en_s[1] = 1'b1; clr_s[1] = (i < 2);
      p2 = p1; p1 = v;
      rand_in(0); rand_in(2);
      tick();
    end
    chk("aligned_fail", 1, 91'(fail_o[1]), 91'd0);
    chk("aligned_cnt", 1, 91'(mcnt_o[1]), 91'd0);
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      v = rnd91();
      ya_s[1] = v; yb_s[1] = v;
      rand_in(0); rand_in(2);
      tick();
      seen = fail_o[1];
    end
    chk("undelayed_fail", 1, 91'(seen), 91'd1);

    // random traffic with occasional mid-run reset
    for (int i = 0; i < 300; i++) begin
      rst_s = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 3; k++) rand_in(k);
      tick();
    end
    rst_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) rand_in(k);
      tick();
    end
    chk("sb_drain", 0, 91'(q0.size()), 91'd0);
    chk("sb_drain", 1, 91'(q1.size()), 91'd0);
    chk("sb_drain", 2, 91'(q2.size()), 91'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
